// File: rtl/branch_pkg.sv
`default_nettype none
// =============================================================================
// branch_pkg : 2-bit predictor state type and encoding constants | rev 1.0
// =============================================================================
package branch_pkg;

  typedef logic [1:0] bp_state_t;

  localparam bp_state_t ST_STRONG_TAKEN     = 2'd0;
  localparam bp_state_t ST_WEAK_TAKEN       = 2'd1;
  localparam bp_state_t ST_WEAK_NOT_TAKEN   = 2'd2;
  localparam bp_state_t ST_STRONG_NOT_TAKEN = 2'd3;

  // The taken half of the encoding is states 0 and 1.
  function automatic logic bp_is_taken(input bp_state_t s);
    return (s == ST_STRONG_TAKEN) || (s == ST_WEAK_TAKEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_state_next.sv
`default_nettype none
// =============================================================================
// bp_state_next : saturating 2-bit counter training step | rev 1.0
// =============================================================================
module bp_state_next
  import branch_pkg::*;
(
  input  bp_state_t i_state,
  input  logic      i_taken,
  output bp_state_t o_state_next
);

  // Taken moves toward strongly-taken (0), not-taken toward strongly-not-taken (3).
  always_comb begin
    o_state_next = i_state;
    if (i_taken) begin
      if (i_state != ST_STRONG_TAKEN) begin
        o_state_next = i_state - 2'd1;
      end
    end else begin
      if (i_state != ST_STRONG_NOT_TAKEN) begin
        o_state_next = i_state + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_pattern_table.sv
`default_nettype none
// =============================================================================
// branch_pattern_table : gshare-indexed 2-bit pattern table with history and
//                        saturating mispredict counter | rev 1.0
// =============================================================================
module branch_pattern_table
  import branch_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clock,
  input  logic              i_init,
  input  logic              i_pred_valid,
  input  logic [7:0]        i_pred_pc,
  output logic              o_pred_valid,
  output logic              o_pred_taken,
  output logic [1:0]        o_pred_state,
  output logic [IDX_W-1:0]  o_pred_index,
  input  logic              i_upd_valid,
  input  logic [IDX_W-1:0]  i_upd_index,
  input  logic              i_upd_taken,
  input  logic              i_upd_mispredict,
  output logic [HIST_W-1:0] o_ghr,
  output logic [CNT_W-1:0]  o_mispredict_count
);

  localparam int NUM_ENT = 2 ** IDX_W;

  bp_state_t          table_q [NUM_ENT];
  bp_state_t          table_d [NUM_ENT];
  logic [HIST_W-1:0]  ghr_q, ghr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pred_valid_q;
  logic               pred_taken_q, pred_taken_d;
  bp_state_t          pred_state_q, pred_state_d;
  logic [IDX_W-1:0]   pred_index_q, pred_index_d;

  bp_state_t          w_upd_cur;
  bp_state_t          w_upd_next;
  logic [IDX_W-1:0]   w_ghr_ext;
  logic [IDX_W-1:0]   w_lookup_idx;
  logic               w_pc_unused;

  assign w_upd_cur = table_q[i_upd_index];

  bp_state_next u_state_next (
    .i_state      (w_upd_cur),
    .i_taken      (i_upd_taken),
    .o_state_next (w_upd_next)
  );

  always_comb begin
    w_ghr_ext             = '0;
    w_ghr_ext[HIST_W-1:0] = ghr_q;
  end

  // Index uses the history as it stands before any same-cycle update shifts it.
  assign w_lookup_idx = i_pred_pc[IDX_W+1:2] ^ w_ghr_ext;
  assign w_pc_unused  = ^i_pred_pc;

  always_comb begin
    table_d      = table_q;
    ghr_d        = ghr_q;
    cnt_d        = cnt_q;
    pred_state_d = pred_state_q;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;

    if (i_upd_valid) begin
      table_d[i_upd_index] = w_upd_next;
      ghr_d                = (ghr_q << 1) | HIST_W'(i_upd_taken);
      if (i_upd_mispredict && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A same-index update in this cycle is forwarded so the lookup sees it.
    if (i_pred_valid) begin
      pred_index_d = w_lookup_idx;
      if (i_upd_valid && (i_upd_index == w_lookup_idx)) begin
        pred_state_d = w_upd_next;
      end else begin
        pred_state_d = table_q[w_lookup_idx];
      end
      pred_taken_d = bp_is_taken(pred_state_d);
    end
  end

  always_ff @(posedge i_clock or posedge i_init) begin
    if (i_init) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        table_q[i] <= ST_STRONG_TAKEN;
      end
      ghr_q        <= '0;
      cnt_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_state_q <= ST_STRONG_TAKEN;
      pred_index_q <= '0;
    end else begin
      table_q      <= table_d;
      ghr_q        <= ghr_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= i_pred_valid;
      pred_taken_q <= pred_taken_d;
      pred_state_q <= pred_state_d;
      pred_index_q <= pred_index_d;
    end
  end

  assign o_pred_valid       = pred_valid_q;
  assign o_pred_taken       = pred_taken_q;
  assign o_pred_state       = pred_state_q;
  assign o_pred_index       = pred_index_q;
  assign o_ghr              = ghr_q;
  assign o_mispredict_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/branch_pattern_table.md
BRANCH_PATTERN_TABLE -- requirements
Module: branch_pattern_table

Interface
REQ-001 SHALL have parameter IDX_W, default 4, table index width; the table holds 2**IDX_W entries.
REQ-002 SHALL have parameter HIST_W, default 4, global history width, with HIST_W <= IDX_W.
REQ-003 SHALL have parameter CNT_W, default 16, misprediction counter width.
REQ-004 SHALL have port i_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_init, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_pred_valid, input, 1, prediction lookup request.
REQ-007 SHALL have port i_pred_pc, input, 8, branch address for lookup.
REQ-008 SHALL have port o_pred_valid, input-registered output, 1, lookup result valid.
REQ-009 SHALL have port o_pred_taken, output, 1, predicted direction (1 = taken).
REQ-010 SHALL have port o_pred_state, output, 2, 2-bit state of the looked-up entry.
REQ-011 SHALL have port o_pred_index, output, IDX_W, index used; returned later on the update port.
REQ-012 SHALL have port i_upd_valid, input, 1, resolved-branch update request.
REQ-013 SHALL have port i_upd_index, input, IDX_W, entry to train.
REQ-014 SHALL have port i_upd_taken, input, 1, resolved outcome (the branch result).
REQ-015 SHALL have port i_upd_mispredict, input, 1, resolution disagreed with the prediction.
REQ-016 SHALL have port o_ghr, output, HIST_W, current global history register.
REQ-017 SHALL have port o_mispredict_count, output, CNT_W, saturating count of mispredictions.

Function
REQ-018 State encoding SHALL be: 0 strongly taken, 1 weakly taken, 2 weakly not-taken, 3 strongly not-taken.
REQ-019 Training SHALL be: taken decrements the state and saturates at 0; not-taken increments it and saturates at 3.
REQ-020 o_pred_taken SHALL be 1 exactly when the state is 0 or 1.
REQ-021 Lookup index SHALL be i_pred_pc[IDX_W+1:2] XOR zero-extended o_ghr.
REQ-022 Lookup latency SHALL be one cycle: o_pred_* are registered; o_pred_valid is the registered copy of i_pred_valid.
REQ-023 When o_pred_valid is 0, o_pred_taken, o_pred_state and o_pred_index SHALL hold their last values.
REQ-024 On i_upd_valid, the entry at i_upd_index SHALL be trained with i_upd_taken at the clock edge.
REQ-025 On the same edge, o_ghr SHALL shift left with i_upd_taken entering bit 0.
REQ-026 On i_upd_valid with i_upd_mispredict, o_mispredict_count SHALL increment and saturate at all-ones.
REQ-027 i_upd_mispredict SHALL be ignored when i_upd_valid is 0.
REQ-028 Simultaneous lookup and update, same index: the lookup SHALL return the post-update state (bypass).
REQ-029 Simultaneous lookup and update: the lookup index SHALL use o_ghr before the shift.
REQ-030 Simultaneous lookup and update, different indices: both SHALL complete independently in the same cycle.
REQ-031 Back-to-back lookups and updates every cycle SHALL be accepted with no stall; the block has no backpressure.

Reset
REQ-032 Asserting i_init SHALL immediately set every table entry to 0 and clear o_ghr, o_mispredict_count, o_pred_valid, o_pred_taken, o_pred_state and o_pred_index to 0.
REQ-033 While i_init is high, all requests SHALL be ignored.
REQ-034 Reset mid-operation SHALL discard any in-flight lookup: no o_pred_valid pulse follows reset release unless a new request arrives.

Structure
REQ-035 A shared package branch_pkg SHALL hold the four state-encoding constants and the 2-bit state typedef.
REQ-036 The saturating next-state rule SHALL be one combinational sub-module, bp_state_next (inputs: state, taken; output: next state), instantiated on the update path.
REQ-037 The table SHALL be a flop array; no memory macro.

Verification
REQ-038 Reset, then lookup pc 0x00: next cycle o_pred_valid=1, o_pred_state=0, o_pred_taken=1, o_pred_index=0.
REQ-039 Three not-taken updates to index 5, then lookup of index 5: state sequence 1, 2, 3; lookup returns state 3, taken=0; a fourth not-taken update leaves state 3.
REQ-040 Updates with outcomes 1, 0, 1, 1 starting from o_ghr=0: o_ghr ends at 4'b1011; lookup of pc 0x04 then uses index 4'b1010.
REQ-041 Same-cycle update (index 3, not-taken) and lookup resolving to index 3 from reset state: lookup returns state 1 (bypass).
REQ-042 2**CNT_W+2 mispredict updates with CNT_W=4: count holds at 15; an update with i_upd_valid=0 and i_upd_mispredict=1 leaves it unchanged.
REQ-043 i_init pulsed while o_pred_valid is 1 and entries are trained: all outputs read 0 in the same cycle, and a subsequent lookup returns state 0.
